// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back sequencing
// for a small RV32 subset, with a sticky illegal-opcode trap and a retired counter.
module mc_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         inst,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic [2:0]          imm_sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_src,
    output logic                reg_we,
    output logic                alu_src_b,
    output logic                wb_sel,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_FETCH  = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_EXEC   = 3'b011;
    localparam logic [2:0] S_MEM    = 3'b100;
    localparam logic [2:0] S_WB     = 3'b101;
    localparam logic [2:0] S_TRAP   = 3'b110;

    localparam logic [2:0] C_R     = 3'd0;
    localparam logic [2:0] C_SHIFT = 3'd1;
    localparam logic [2:0] C_ALUI  = 3'd2;
    localparam logic [2:0] C_LOAD  = 3'd3;
    localparam logic [2:0] C_STORE = 3'd4;
    localparam logic [2:0] C_BR    = 3'd5;
    localparam logic [2:0] C_U     = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [2:0]          imm_sel_q, imm_sel_d;
    logic [2:0]          cls_q, cls_d;
    logic                illegal_q, illegal_d;
    logic                run_q, run_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic       dec_legal;
    logic [2:0] dec_cls;
    logic [2:0] dec_imm;

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        dec_imm   = 3'b000;
        case (inst[6:0])
            7'b0110011: begin dec_cls = C_R;     dec_imm = 3'b000; end
            7'b0010011: begin
                if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
                    dec_cls = C_SHIFT;
                    dec_imm = 3'b000;
                end else begin
                    dec_cls = C_ALUI;
                    dec_imm = 3'b001;
                end
            end
            7'b0000011: begin dec_cls = C_LOAD;  dec_imm = 3'b001; end
            7'b0100011: begin dec_cls = C_STORE; dec_imm = 3'b010; end
            7'b1100011: begin dec_cls = C_BR;    dec_imm = 3'b011; end
            7'b0110111,
            7'b0010111: begin dec_cls = C_U;     dec_imm = 3'b100; end
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        imm_sel_d = imm_sel_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        run_d     = run_q;
        retired_d = retired_q;
        case (state_q)
            // run_q delays the first FETCH to the second edge after reset release.
            S_IDLE: begin
                run_d = 1'b1;
                if (run_q) state_d = S_FETCH;
            end
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_legal) begin
                    cls_d     = dec_cls;
                    imm_sel_d = dec_imm;
                    state_d   = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                if (cls_q == C_BR)
                    state_d = S_FETCH;
                else if (cls_q == C_LOAD || cls_q == C_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_FETCH &&
            (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
            retired_d = retired_q + RETIRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            imm_sel_q <= 3'b000;
            cls_q     <= C_R;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            imm_sel_q <= imm_sel_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            run_q     <= run_d;
            retired_q <= retired_d;
        end
    end

    // Strobes decode from the registered state only, so an asynchronous reset clears them at once.
    always_comb begin
        mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
        mem_we    = (state_q == S_MEM) && (cls_q == C_STORE);
        addr_sel  = (state_q == S_MEM);
        ir_we     = (state_q == S_FETCH) && mem_ready;
        pc_we     = ((state_q == S_FETCH) && mem_ready) ||
                    ((state_q == S_EXEC) && (cls_q == C_BR) && branch_taken);
        pc_src    = (state_q == S_EXEC) && (cls_q == C_BR);
        reg_we    = (state_q == S_WB);
        alu_src_b = (state_q == S_EXEC) && (cls_q != C_R) && (cls_q != C_BR);
        wb_sel    = (state_q == S_WB) && (cls_q == C_LOAD);
    end

    assign imm_sel = imm_sel_q;
    assign illegal = illegal_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instructions, per-instruction expectations
// queued by the driver and compared by a monitor when each instruction retires.
module tb_mc_ctrl;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   inst;
    logic          mem_ready;
    logic          branch_taken;
    logic [2:0]    imm_sel;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we;
    logic          alu_src_b, wb_sel, illegal;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    mc_ctrl #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .imm_sel(imm_sel), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
        .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] imm;
        logic [7:0] cyc;
        logic [3:0] memreq_n;
        logic [3:0] memwe_n;
        logic [1:0] regwe_n;
        logic [1:0] pcwe_n;
        logic [1:0] brpc_n;
        logic       alu_b;
        logic       wbsel;
        logic [3:0] ret;
    } rec_t;

    rec_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_ret  = 4'd0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference classification straight from the opcode table: 0 R, 1 shift-imm, 2 other
    // ALU-imm, 3 load, 4 store, 5 branch, 6 LUI/AUIPC, 7 unsupported.
    function automatic int cls_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return 0;
            7'b0010011: return (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? 1 : 2;
            7'b0000011: return 3;
            7'b0100011: return 4;
            7'b1100011: return 5;
            7'b0110111, 7'b0010111: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] gen_inst(input int k);
        logic [31:0] w;
        logic [2:0]  f3;
        w = $urandom;
        case (k)
            0: w[6:0] = 7'b0110011;
            1: begin w[6:0] = 7'b0010011; w[14:12] = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001; end
            2: begin
                w[6:0] = 7'b0010011;
                do f3 = 3'($urandom); while (f3 == 3'b001 || f3 == 3'b101);
                w[14:12] = f3;
            end
            3: w[6:0] = 7'b0000011;
            4: w[6:0] = 7'b0100011;
            5: w[6:0] = 7'b1100011;
            6: w[6:0] = 7'b0110111;
            default: w[6:0] = 7'b0010111;
        endcase
        return w;
    endfunction

    task automatic push_exp(input logic [31:0] w, input int fw, input int mw, input bit tk);
        rec_t r;
        int   c;
        int   imm_tab[7] = '{0, 0, 1, 1, 2, 3, 4};
        c = cls_of(w);
        exp_ret    = exp_ret + 4'd1;
        r.imm      = 3'(imm_tab[c]);
        r.cyc      = 8'(fw + ((c == 5) ? 3 : (c == 4) ? 4 + mw : (c == 3) ? 5 + mw : 4));
        r.memreq_n = 4'(fw + 1 + ((c == 3 || c == 4) ? mw + 1 : 0));
        r.memwe_n  = 4'((c == 4) ? mw + 1 : 0);
        r.regwe_n  = (c == 4 || c == 5) ? 2'd0 : 2'd1;
        r.pcwe_n   = (c == 5 && tk) ? 2'd2 : 2'd1;
        r.brpc_n   = (c == 5 && tk) ? 2'd1 : 2'd0;
        r.alu_b    = !(c == 0 || c == 5);
        r.wbsel    = (c == 3);
        r.ret      = exp_ret;
        exp_q.push_back(r);
    endtask

    // Drives mem_ready for the fetch of w with fw wait cycles; inst carries junk elsewhere.
    task automatic do_fetch(input logic [31:0] w, input int fw);
        int  waits = fw;
        int  guard = 0;
        bit  done  = 0;
        while (!done) begin
            @(negedge clk);
            branch_taken = 1'($urandom);
            guard++;
            if (guard > 100) begin
                check("fetch_timeout", 1, 0);
                return;
            end
            if (mem_req && !addr_sel) begin
                if (waits > 0) begin
                    mem_ready = 1'b0; inst = $urandom; waits--;
                end else begin
                    mem_ready = 1'b1; inst = w; done = 1;
                end
            end else begin
                mem_ready = 1'($urandom); inst = $urandom;
            end
        end
    endtask

    task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input bit tk);
        int  c = cls_of(w);
        int  waits = mw;
        int  guard = 0;
        bit  done = 0;
        push_exp(w, fw, mw, tk);
        do_fetch(w, fw);
        @(negedge clk);
        mem_ready = 1'($urandom); branch_taken = tk;
        @(negedge clk);
        mem_ready = 1'($urandom); inst = $urandom;
        if (c == 3 || c == 4) begin
            while (!done) begin
                @(negedge clk);
                guard++;
                if (guard > 100) begin
                    check("mem_timeout", 1, 0);
                    return;
                end
                inst = $urandom;
                if (mem_req && addr_sel) begin
                    if (waits > 0) begin mem_ready = 1'b0; waits--; end
                    else begin mem_ready = 1'b1; done = 1; end
                end else begin
                    mem_ready = 1'($urandom);
                end
            end
        end
    endtask

    // Monitor: accumulates per-instruction activity; compares when the next FETCH begins.
    int         m_cyc, m_memreq, m_memwe, m_regwe, m_irwe, m_pcwe, m_brpc;
    logic       m_alub, m_wbsel, m_active;
    logic [2:0] m_prev = 3'd0;

    always begin
        rec_t e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            m_active = 1'b0;
            m_prev   = 3'd0;
        end else begin
            if (state == 3'd1 && m_active &&
                (m_prev == 3'd3 || m_prev == 3'd4 || m_prev == 3'd5)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("imm_sel", imm_sel, e.imm);
                    check("latency", m_cyc, e.cyc);
                    check("mem_req_cycles", m_memreq, e.memreq_n);
                    check("mem_we_cycles", m_memwe, e.memwe_n);
                    check("reg_we_pulses", m_regwe, e.regwe_n);
                    check("ir_we_pulses", m_irwe, 1);
                    check("pc_we_pulses", m_pcwe, e.pcwe_n);
                    check("branch_pc_load", m_brpc, e.brpc_n);
                    check("alu_src_b", m_alub, e.alu_b);
                    check("wb_sel", m_wbsel, e.wbsel);
                    check("retired", retired, e.ret);
                end
            end
            if (state == 3'd1 && m_prev != 3'd1) begin
                m_active = 1'b1;
                m_cyc = 0; m_memreq = 0; m_memwe = 0; m_regwe = 0;
                m_irwe = 0; m_pcwe = 0; m_brpc = 0; m_alub = 1'b0; m_wbsel = 1'b0;
            end
            if (m_active) begin
                m_cyc++;
                m_memreq += int'(mem_req);
                m_memwe  += int'(mem_we);
                m_regwe  += int'(reg_we);
                m_irwe   += int'(ir_we);
                m_pcwe   += int'(pc_we);
                m_brpc   += int'(pc_we && pc_src);
                if (state == 3'd3) m_alub = alu_src_b;
                if (wb_sel) m_wbsel = 1'b1;
            end
            m_prev = state;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_imm_sel"}, imm_sel, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_retired"}, retired, 0);
        check({tag, "_outputs"}, {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
                                  reg_we, alu_src_b, wb_sel}, 0);
    endtask

    task automatic check_startup();
        @(posedge clk); #1;
        check("start_edge1_idle", state, 0);
        @(posedge clk); #1;
        check("start_edge2_fetch", state, 1);
    endtask

    initial begin
        logic [31:0] dir_w[10] = '{32'h003100B3, 32'h0020A223, 32'h00208463, 32'h00208463,
                                   32'h00209093, 32'h00108093, 32'h123450B7, 32'h0000A103,
                                   32'h00000097, 32'h0020A223};
        int          dir_fw[10] = '{0, 0, 0, 1, 0, 2, 0, 0, 0, 1};
        int          dir_mw[10] = '{0, 2, 0, 0, 0, 0, 0, 1, 0, 0};
        bit          dir_tk[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        logic [31:0] w;
        int          seen;

        rst_n = 1'b0; inst = 32'h0; mem_ready = 1'b0; branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check_startup();

        for (int i = 0; i < 10; i++) run_instr(dir_w[i], dir_fw[i], dir_mw[i], dir_tk[i]);
        for (int i = 0; i < 80; i++) begin
            w = gen_inst($urandom_range(0, 7));
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset in the middle of a stalled store.
        do_fetch(32'h0020A223, 0);
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); mem_ready = 1'b0;
        #1;
        check("mid_store_mem_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1; exp_ret = 4'd0;
        check_startup();

        run_instr(32'h003100B3, 0, 0, 0);

        // Unsupported opcode: absorbing trap with no strobes until reset.
        do_fetch(32'h0000006F, 0);
        @(negedge clk); mem_ready = 1'($urandom);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom); inst = $urandom; branch_taken = 1'($urandom);
            #1;
            seen += int'(mem_req | mem_we | ir_we | pc_we | reg_we);
        end
        check("trap_state", state, 6);
        check("trap_illegal", illegal, 1);
        check("trap_strobes", seen, 0);
        check("trap_retired_frozen", retired, exp_ret);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("trap_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_startup();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
